// File: rtl/ooo_top.sv
// ooo_top: front end of the out-of-order RV32I core.
//
// Purpose:
//   PC generation -> synchronous instruction memory -> fetch register ->
//   RV32I decoder (registered) -> 2-entry skid buffer. The skid buffer output
//   is the edge of this block; rename is not part of it, so its downstream
//   ready is tied high.
//
// Ports (top):
//   clk  in  1  system clock, rising edge
//   rst  in  1  asynchronous, active-high reset
//
// Observation is hierarchical. The decode_to_skid_* nets and
// skid_to_decode_ready keep their names so they can be probed and forced.
// The memory array instruction_memory.mem can be preloaded before reset
// is released.

// ---------------------------------------------------------------------------
// ooo_imem: 128 x 32 instruction memory with a 1-cycle synchronous read.
//
// Ports:
//   clk_i    in   1   clock
//   rst_i    in   1   async reset, clears the read register only
//   en_i     in   1   read enable; when low the last read word is held
//   addr_i   in   7   word read address
//   we_i     in   1   write enable (loader port)
//   waddr_i  in   7   word write address
//   wdata_i  in   T   write data
//   rdata_o  out  T   registered read data
// ---------------------------------------------------------------------------
module ooo_imem #(
    parameter type T = logic [31:0]
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [6:0] addr_i,
    input  logic       we_i,
    input  logic [6:0] waddr_i,
    input  T           wdata_i,
    output T           rdata_o
);
    T mem [0:127];
    T rdata_q;

    // Array has no reset, so contents preloaded before reset release survive it.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Holding the read register while en_i is low keeps the fetched word
    // stable during a stall without having to replay the address.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (en_i) begin
            rdata_q <= mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// ---------------------------------------------------------------------------
// ooo_skid: 2-entry valid/ready skid buffer.
//
// Ports:
//   clk_i    in   1     clock
//   rst_i    in   1     async reset
//   valid_i  in   1     upstream valid
//   data_i   in   D_T   upstream payload
//   ready_o  out  1     upstream ready (registered: not full)
//   valid_o  out  1     downstream valid
//   data_o   out  D_T   downstream payload
//   ready_i  in   1     downstream ready
// ---------------------------------------------------------------------------
module ooo_skid #(
    parameter type D_T = logic
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic valid_i,
    input  D_T   data_i,
    output logic ready_o,
    output logic valid_o,
    output D_T   data_o,
    input  logic ready_i
);
    logic main_valid_q, skid_valid_q;
    D_T   main_q, skid_q;

    // Ready depends only on state, which breaks the combinational ready path.
    assign ready_o = !skid_valid_q;
    assign valid_o = main_valid_q;
    assign data_o  = main_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else if (ready_i || !main_valid_q) begin
            // Output slot drains or is empty: refill from skid first to keep order.
            if (skid_valid_q) begin
                main_q       <= skid_q;
                main_valid_q <= 1'b1;
                skid_valid_q <= 1'b0;
            end else begin
                main_q       <= data_i;
                main_valid_q <= valid_i;
            end
        end else if (valid_i && ready_o) begin
            // Output stalled: park the beat that was already accepted.
            skid_q       <= data_i;
            skid_valid_q <= 1'b1;
        end
    end
endmodule

// ---------------------------------------------------------------------------
// ooo_top
// ---------------------------------------------------------------------------
module ooo_top #(
    parameter type T = logic [31:0]
) (
    input logic clk,
    input logic rst
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] FU_ALU = 2'b00;
    localparam logic [1:0] FU_BR  = 2'b01;
    localparam logic [1:0] FU_LSU = 2'b10;

    typedef struct packed {
        logic [8:0] pc;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        T           imm;
        logic       alusrc;
        logic       branch;
        logic [1:0] aluop;
        logic [1:0] futype;
        logic       memread;
        logic       memwrite;
        logic       regwrite;
    } dec_t;

    // ---------------- PC and fetch ----------------
    logic [8:0] pc_q, pc_d;
    logic [8:0] fetch_pc_q;
    logic       fetch_valid_q;
    T           fetch_instr;
    logic       fetch_accept, decode_accept;

    logic       dec_valid_q;
    dec_t       dec_q, dec_d;

    logic       skid_to_decode_ready;
    logic       skid_ready;

    // Stall chain: fetch advances only when its word moves into decode.
    assign decode_accept = !dec_valid_q || skid_to_decode_ready;
    assign fetch_accept  = !fetch_valid_q || decode_accept;
    // 9-bit add wraps 0x1FC -> 0x000 on its own.
    assign pc_d          = fetch_accept ? pc_q + 9'd4 : pc_q;

    ooo_imem #(.T(T)) instruction_memory (
        .clk_i   (clk),
        .rst_i   (rst),
        .en_i    (fetch_accept),
        .addr_i  (pc_q[8:2]),
        .we_i    (1'b0),
        .waddr_i (7'd0),
        .wdata_i ('0),
        .rdata_o (fetch_instr)
    );

    // fetch_pc_q/fetch_valid_q update on the same enable as the memory read
    // register, so the three together form the fetch stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= '0;
            fetch_pc_q    <= '0;
            fetch_valid_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            if (fetch_accept) begin
                fetch_pc_q    <= pc_q;
                fetch_valid_q <= 1'b1;
            end
        end
    end

    // ---------------- decode ----------------
    T imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [6:0] opcode;

    assign opcode = fetch_instr[6:0];
    assign imm_i  = {{20{fetch_instr[31]}}, fetch_instr[31:20]};
    assign imm_s  = {{20{fetch_instr[31]}}, fetch_instr[31:25], fetch_instr[11:7]};
    assign imm_b  = {{19{fetch_instr[31]}}, fetch_instr[31], fetch_instr[7],
                     fetch_instr[30:25], fetch_instr[11:8], 1'b0};
    assign imm_u  = {fetch_instr[31:12], 12'b0};
    assign imm_j  = {{11{fetch_instr[31]}}, fetch_instr[31], fetch_instr[19:12],
                     fetch_instr[20], fetch_instr[30:21], 1'b0};

    // Unused register fields stay 0; unknown opcodes decode to an all-zero NOP
    // that still carries its pc.
    always_comb begin
        dec_d    = '0;
        dec_d.pc = fetch_pc_q;
        case (opcode)
            OP_R: begin
                dec_d.rs1      = fetch_instr[19:15];
                dec_d.rs2      = fetch_instr[24:20];
                dec_d.rd       = fetch_instr[11:7];
                dec_d.aluop    = 2'b10;
                dec_d.futype   = FU_ALU;
                dec_d.regwrite = 1'b1;
            end
            OP_IALU: begin
                dec_d.rs1      = fetch_instr[19:15];
                dec_d.rd       = fetch_instr[11:7];
                dec_d.imm      = imm_i;
                dec_d.alusrc   = 1'b1;
                dec_d.aluop    = 2'b10;
                dec_d.futype   = FU_ALU;
                dec_d.regwrite = 1'b1;
            end
            OP_LOAD: begin
                dec_d.rs1      = fetch_instr[19:15];
                dec_d.rd       = fetch_instr[11:7];
                dec_d.imm      = imm_i;
                dec_d.alusrc   = 1'b1;
                dec_d.futype   = FU_LSU;
                dec_d.memread  = 1'b1;
                dec_d.regwrite = 1'b1;
            end
            OP_STORE: begin
                dec_d.rs1      = fetch_instr[19:15];
                dec_d.rs2      = fetch_instr[24:20];
                dec_d.imm      = imm_s;
                dec_d.alusrc   = 1'b1;
                dec_d.futype   = FU_LSU;
                dec_d.memwrite = 1'b1;
            end
            OP_BRANCH: begin
                dec_d.rs1      = fetch_instr[19:15];
                dec_d.rs2      = fetch_instr[24:20];
                dec_d.imm      = imm_b;
                dec_d.branch   = 1'b1;
                dec_d.aluop    = 2'b01;
                dec_d.futype   = FU_BR;
            end
            OP_LUI: begin
                dec_d.rd       = fetch_instr[11:7];
                dec_d.imm      = imm_u;
                dec_d.alusrc   = 1'b1;
                dec_d.aluop    = 2'b11;
                dec_d.futype   = FU_ALU;
                dec_d.regwrite = 1'b1;
            end
            OP_AUIPC: begin
                dec_d.rd       = fetch_instr[11:7];
                dec_d.imm      = imm_u;
                dec_d.alusrc   = 1'b1;
                dec_d.futype   = FU_ALU;
                dec_d.regwrite = 1'b1;
            end
            OP_JAL: begin
                dec_d.rd       = fetch_instr[11:7];
                dec_d.imm      = imm_j;
                dec_d.alusrc   = 1'b1;
                dec_d.branch   = 1'b1;
                dec_d.futype   = FU_BR;
                dec_d.regwrite = 1'b1;
            end
            OP_JALR: begin
                dec_d.rs1      = fetch_instr[19:15];
                dec_d.rd       = fetch_instr[11:7];
                dec_d.imm      = imm_i;
                dec_d.alusrc   = 1'b1;
                dec_d.branch   = 1'b1;
                dec_d.futype   = FU_BR;
                dec_d.regwrite = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_valid_q <= 1'b0;
            dec_q       <= '0;
        end else if (decode_accept) begin
            dec_valid_q <= fetch_valid_q;
            dec_q       <= dec_d;
        end
    end

    logic       decode_to_skid_valid;
    logic [8:0] decode_to_skid_pc;
    logic [4:0] decode_to_skid_rs1, decode_to_skid_rs2, decode_to_skid_rd;
    T           decode_to_skid_immediate;
    logic       decode_to_skid_ALUsrc, decode_to_skid_Branch;
    logic [1:0] decode_to_skid_ALUOp, decode_to_skid_FUtype;
    logic       decode_to_skid_Memread, decode_to_skid_Memwrite, decode_to_skid_Regwrite;

    assign decode_to_skid_valid     = dec_valid_q;
    assign decode_to_skid_pc        = dec_q.pc;
    assign decode_to_skid_rs1       = dec_q.rs1;
    assign decode_to_skid_rs2       = dec_q.rs2;
    assign decode_to_skid_rd        = dec_q.rd;
    assign decode_to_skid_immediate = dec_q.imm;
    assign decode_to_skid_ALUsrc    = dec_q.alusrc;
    assign decode_to_skid_Branch    = dec_q.branch;
    assign decode_to_skid_ALUOp     = dec_q.aluop;
    assign decode_to_skid_FUtype    = dec_q.futype;
    assign decode_to_skid_Memread   = dec_q.memread;
    assign decode_to_skid_Memwrite  = dec_q.memwrite;
    assign decode_to_skid_Regwrite  = dec_q.regwrite;

    // ---------------- skid buffer ----------------
    logic skid_out_valid;
    dec_t skid_out_data;
    logic skid_in_valid;

    assign skid_to_decode_ready = skid_ready;
    // Qualify the push with the boundary ready net so that the skid and the
    // decode stage always agree on whether a beat was handed over.
    assign skid_in_valid = decode_to_skid_valid && skid_to_decode_ready;

    ooo_skid #(.D_T(dec_t)) u_skid (
        .clk_i   (clk),
        .rst_i   (rst),
        .valid_i (skid_in_valid),
        .data_i  (dec_q),
        .ready_o (skid_ready),
        .valid_o (skid_out_valid),
        .data_o  (skid_out_data),
        .ready_i (1'b1)
    );

    // Rename is outside this block; the skid output has no consumer here.
    logic unused_skid_out;
    assign unused_skid_out = skid_out_valid ^ (^skid_out_data);
endmodule

// File: tb/tb_ooo_top.sv
// Bench for ooo_top: preloads the instruction memory, releases reset and
// checks every decoded instruction against an expected-result queue.
module tb_ooo_top;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    ooo_top dut (.clk(clk), .rst(rst));

    typedef struct packed {
        logic [8:0]  pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        alusrc;
        logic        branch;
        logic [1:0]  aluop;
        logic [1:0]  fu;
        logic        mr;
        logic        mw;
        logic        rw;
    } exp_t;

    exp_t        exp_tab [128];
    exp_t        exp_q [$];
    logic [31:0] prog [128];
    int          n_tests = 0;
    int          n_fail  = 0;

    function automatic exp_t mk(input logic [8:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic [31:0] imm, input logic alusrc,
                                input logic branch, input logic [1:0] aluop, input logic [1:0] fu,
                                input logic mr, input logic mw, input logic rw);
        exp_t e;
        e.pc = pc; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.imm = imm;
        e.alusrc = alusrc; e.branch = branch; e.aluop = aluop; e.fu = fu;
        e.mr = mr; e.mw = mw; e.rw = rw;
        return e;
    endfunction

    function automatic exp_t observe();
        exp_t o;
        o.pc = dut.decode_to_skid_pc; o.rs1 = dut.decode_to_skid_rs1;
        o.rs2 = dut.decode_to_skid_rs2; o.rd = dut.decode_to_skid_rd;
        o.imm = dut.decode_to_skid_immediate; o.alusrc = dut.decode_to_skid_ALUsrc;
        o.branch = dut.decode_to_skid_Branch; o.aluop = dut.decode_to_skid_ALUOp;
        o.fu = dut.decode_to_skid_FUtype; o.mr = dut.decode_to_skid_Memread;
        o.mw = dut.decode_to_skid_Memwrite; o.rw = dut.decode_to_skid_Regwrite;
        return o;
    endfunction

    // Instruction encoders (funct fields irrelevant to this decoder are 0).
    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_u(input logic [6:0] op, input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, op};
    endfunction
    function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic build_program();
        prog[0]  = enc_r(5'd1, 5'd2, 5'd3);                       // ADD  x1,x2,x3
        prog[1]  = enc_i(7'b0010011, 5'd4, 5'd5, 12'd100);        // ADDI x4,x5,100
        prog[2]  = enc_i(7'b0000011, 5'd6, 5'd7, 12'd8);          // LW   x6,8(x7)
        prog[3]  = enc_s(5'd9, 5'd8, 12'd12);                     // SW   x8,12(x9)
        prog[4]  = enc_b(5'd10, 5'd11, 13'd16);                   // BEQ  x10,x11,16
        prog[5]  = enc_u(7'b0110111, 5'd12, 20'h12345);           // LUI  x12,0x12345
        prog[6]  = enc_u(7'b0010111, 5'd13, 20'h01000);           // AUIPC x13
        prog[7]  = enc_j(5'd14, 21'd32);                          // JAL  x14,32
        prog[8]  = enc_i(7'b1100111, 5'd15, 5'd16, 12'd8);        // JALR x15,8(x16)
        prog[9]  = enc_i(7'b0010011, 5'd17, 5'd18, 12'hFFF);      // ADDI x17,x18,-1
        prog[10] = 32'hFFFF_FFFF;                                 // opcode 1111111 -> NOP
        exp_tab[0]  = mk(9'h000, 5'd2,  5'd3,  5'd1,  32'd0,          1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1);
        exp_tab[1]  = mk(9'h004, 5'd5,  5'd0,  5'd4,  32'd100,        1'b1, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1);
        exp_tab[2]  = mk(9'h008, 5'd7,  5'd0,  5'd6,  32'd8,          1'b1, 1'b0, 2'b00, 2'b10, 1'b1, 1'b0, 1'b1);
        exp_tab[3]  = mk(9'h00C, 5'd9,  5'd8,  5'd0,  32'd12,         1'b1, 1'b0, 2'b00, 2'b10, 1'b0, 1'b1, 1'b0);
        exp_tab[4]  = mk(9'h010, 5'd10, 5'd11, 5'd0,  32'd16,         1'b0, 1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
        exp_tab[5]  = mk(9'h014, 5'd0,  5'd0,  5'd12, 32'h1234_5000,  1'b1, 1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1);
        exp_tab[6]  = mk(9'h018, 5'd0,  5'd0,  5'd13, 32'h0100_0000,  1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        exp_tab[7]  = mk(9'h01C, 5'd0,  5'd0,  5'd14, 32'd32,         1'b1, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1);
        exp_tab[8]  = mk(9'h020, 5'd16, 5'd0,  5'd15, 32'd8,          1'b1, 1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1);
        exp_tab[9]  = mk(9'h024, 5'd18, 5'd0,  5'd17, 32'hFFFF_FFFF,  1'b1, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1);
        exp_tab[10] = mk(9'h028, 5'd0,  5'd0,  5'd0,  32'd0,          1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        // Filler: ADDI x(i%32), x0, i at every remaining word.
        for (int i = 11; i < 128; i++) begin
            logic [8:0] pcv;
            pcv = 9'(i * 4);
            prog[i]    = enc_i(7'b0010011, 5'(i), 5'd0, 12'(i));
            exp_tab[i] = mk(pcv, 5'd0, 5'd0, 5'(i), 32'(i), 1'b1, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1);
        end
        for (int i = 0; i < 128; i++) dut.instruction_memory.mem[i] = prog[i];
    endtask

    task automatic test_reset();
        exp_t zero;
        zero = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (dut.decode_to_skid_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid got %b exp 0", dut.decode_to_skid_valid);
        end
        n_tests++;
        if (observe() !== zero) begin
            n_fail++; $display("FAIL reset_fields got %h exp %h", observe(), zero);
        end
        n_tests++;
        if (dut.pc_q !== 9'h000) begin
            n_fail++; $display("FAIL reset_pc got %h exp 000", dut.pc_q);
        end
    endtask

    // Full pass over memory plus the wrap back to PC 0, ready held high.
    task automatic test_stream();
        exp_t e, o;
        int first, last, cyc;
        for (int k = 0; k < 132; k++) exp_q.push_back(exp_tab[k % 128]);
        first = -1; last = -1; cyc = 0;
        rst = 1'b0;
        while (exp_q.size() > 0 && cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (dut.decode_to_skid_valid && dut.skid_to_decode_ready) begin
                if (first < 0) first = cyc;
                last = cyc;
                e = exp_q.pop_front();
                o = observe();
                n_tests++;
                if (o !== e) begin
                    n_fail++; $display("FAIL stream_pc%h got %h exp %h", e.pc, o, e);
                end
            end
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL stream_timeout got %0d pending exp 0", exp_q.size());
            exp_q.delete();
        end
        n_tests++;
        if (first < 1 || first > 4) begin
            n_fail++; $display("FAIL stream_latency got %0d exp 1..4", first);
        end
        n_tests++;
        if (last - first != 131) begin
            n_fail++; $display("FAIL stream_back_to_back got %0d cycles exp 131", last - first);
        end
    endtask

    // Asynchronous reset mid-cycle, then refetch from PC 0 up to 0x20.
    task automatic test_midreset();
        exp_t e, o;
        int first, cyc;
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (dut.decode_to_skid_valid !== 1'b0) begin
            n_fail++; $display("FAIL midreset_valid got %b exp 0", dut.decode_to_skid_valid);
        end
        n_tests++;
        if (dut.pc_q !== 9'h000) begin
            n_fail++; $display("FAIL midreset_pc got %h exp 000", dut.pc_q);
        end
        @(negedge clk);
        for (int k = 0; k < 9; k++) exp_q.push_back(exp_tab[k]);
        first = -1; cyc = 0;
        rst = 1'b0;
        while (exp_q.size() > 0 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (dut.decode_to_skid_valid && dut.skid_to_decode_ready) begin
                if (first < 0) first = cyc;
                e = exp_q.pop_front();
                o = observe();
                n_tests++;
                if (o !== e) begin
                    n_fail++; $display("FAIL midreset_pc%h got %h exp %h", e.pc, o, e);
                end
            end
        end
        n_tests++;
        if (exp_q.size() != 0 || first < 1 || first > 4) begin
            n_fail++; $display("FAIL midreset_refetch got pending=%0d first=%0d exp 0 and 1..4", exp_q.size(), first);
            exp_q.delete();
        end
    endtask

    // Ready low for 3 cycles while the ADDI with imm 0xFFF sits at decode.
    task automatic test_stall();
        exp_t e, o, snap;
        logic [8:0] pc_snap;
        int stall_n, cyc;
        for (int k = 9; k < 14; k++) exp_q.push_back(exp_tab[k]);
        stall_n = 0; cyc = 0; snap = '0; pc_snap = '0;
        while (exp_q.size() > 0 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            o = observe();
            if (stall_n < 3 && dut.decode_to_skid_valid && o.pc == 9'h024) begin
                force dut.skid_to_decode_ready = 1'b0;
                if (stall_n == 0) begin
                    snap = o;
                    pc_snap = dut.pc_q;
                    n_tests++;
                    if (o.imm !== 32'hFFFF_FFFF) begin
                        n_fail++; $display("FAIL stall_negimm got %h exp ffffffff", o.imm);
                    end
                end else begin
                    n_tests++;
                    if (o !== snap) begin
                        n_fail++; $display("FAIL stall_hold got %h exp %h", o, snap);
                    end
                    n_tests++;
                    if (dut.pc_q !== pc_snap) begin
                        n_fail++; $display("FAIL stall_pc_hold got %h exp %h", dut.pc_q, pc_snap);
                    end
                end
                stall_n++;
            end else begin
                release dut.skid_to_decode_ready;
                if (dut.decode_to_skid_valid) begin
                    e = exp_q.pop_front();
                    n_tests++;
                    if (o !== e) begin
                        n_fail++; $display("FAIL stall_pc%h got %h exp %h", e.pc, o, e);
                    end
                end
            end
        end
        release dut.skid_to_decode_ready;
        n_tests++;
        if (stall_n != 3 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL stall_sequence got stalls=%0d pending=%0d exp 3 and 0", stall_n, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        build_program();
        test_reset();
        test_stream();
        test_midreset();
        test_stall();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
